// File: rtl/instr_pkg.sv
// Shared instruction field layout, format codes and loader FSM states.
// Both the encoder (pack) and the decode path (unpack) slice words through here.
package instr_pkg;

    localparam int OPC_MSB   = 31;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    localparam int OPC_W    = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        fmt_e                fmt;
        logic [OPC_W-1:0]    opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    shamt;
        logic [FUNCT_W-1:0]  funct;
        logic [IMM_W-1:0]    imm;
        logic [TARGET_W-1:0] target;
    } fields_t;

    // Fields that do not belong to the format are left out of the word.
    function automatic logic [31:0] pack_instr(input fields_t f);
        logic [31:0] w;
        w = '0;
        w[OPC_MSB -: OPC_W] = f.opcode;
        case (f.fmt)
            FMT_R: begin
                w[RS_LSB +: REG_W]    = f.rs;
                w[RT_LSB +: REG_W]    = f.rt;
                w[RD_LSB +: REG_W]    = f.rd;
                w[SHAMT_LSB +: REG_W] = f.shamt;
                w[FUNCT_W-1:0]        = f.funct;
            end
            FMT_I: begin
                w[RS_LSB +: REG_W] = f.rs;
                w[RT_LSB +: REG_W] = f.rt;
                w[IMM_W-1:0]       = f.imm;
            end
            FMT_J:   w[TARGET_W-1:0] = f.target;
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic fields_t unpack_instr(input logic [31:0] w, input fmt_e fmt);
        fields_t f;
        f.fmt    = fmt;
        f.opcode = w[OPC_MSB -: OPC_W];
        f.rs     = w[RS_LSB +: REG_W];
        f.rt     = w[RT_LSB +: REG_W];
        f.rd     = w[RD_LSB +: REG_W];
        f.shamt  = w[SHAMT_LSB +: REG_W];
        f.funct  = w[FUNCT_W-1:0];
        f.imm    = w[IMM_W-1:0];
        f.target = w[TARGET_W-1:0];
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset; rdata reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset: stale entries are never visible past the count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs R/I/J field bundles into 32-bit words, buffers them and writes them
// to instruction memory at consecutive word addresses during a load session.
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, err_q;

    fields_t     fields;
    logic [31:0] packed_word;
    logic        accept, bad_fmt, push, wr_fire;
    logic        fifo_full, fifo_empty;

    assign fields = '{
        fmt:    fmt_e'(in_fmt),
        opcode: in_opcode,
        rs:     in_rs,
        rt:     in_rt,
        rd:     in_rd,
        shamt:  in_shamt,
        funct:  in_funct,
        imm:    in_imm,
        target: in_target
    };

    assign packed_word = pack_instr(fields);

    // Ready comes only from registered state and occupancy, so a full FIFO
    // refuses input even in a cycle where it is also being popped.
    assign in_ready = (state_q == ST_LOAD) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign bad_fmt  = (fields.fmt == FMT_BAD);
    assign push     = accept && !bad_fmt;
    assign mem_we   = !fifo_empty;
    assign wr_fire  = mem_we && mem_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (packed_word),
        .pop   (wr_fire),
        .rdata (mem_wdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pointer wraps with the address width; count pins at 2^ADDR_W instead.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (wr_fire) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (count_q != COUNT_MAX) count_d = count_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= BASE;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            done_q  <= 1'b0;
            if (accept && bad_fmt) err_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= BASE;
                        count_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (finish) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // An empty FIFO means mem_we is low, so nothing is in flight.
                    if (fifo_empty) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr = ptr_q;
    assign count    = count_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized scoreboard bench for instr_encoder_loader plus a narrow-address
// instance for pointer wrap and count saturation.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1, start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic [1:0]        in_fmt = 2'd0;
    logic [5:0]        in_opcode = '0, in_funct = '0;
    logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0]       in_imm = '0;
    logic [25:0]       in_target = '0;
    logic              mem_ready = 1'b0;
    logic              in_ready, mem_we, busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;

    logic        w_start = 1'b0, w_finish = 1'b0, w_in_valid = 1'b0, w_mem_ready = 1'b1;
    logic        w_in_ready, w_mem_we, w_busy, w_done, w_err;
    logic [1:0]  w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic [2:0]  w_count;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .count(count), .busy(busy), .done(done), .err(err)
    );

    instr_encoder_loader #(.ADDR_W(2), .FIFO_DEPTH(2), .BASE_ADDR(3)) dut_wrap (
        .clk(clk), .rst(rst), .start(w_start), .finish(w_finish),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_ready(w_mem_ready),
        .count(w_count), .busy(w_busy), .done(w_done), .err(w_err)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference packing: field values scaled into their bit positions.
    function automatic logic [31:0] model_word(input int fmt, input int op, input int rs,
            input int rt, input int rd, input int sh, input int fn, input int imm, input int tgt);
        longint w;
        case (fmt)
            0:       w = op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
            1:       w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
            default: w = op * 67108864 + tgt;
        endcase
        return w[31:0];
    endfunction

    // Memory-ready generator: either a fixed level or random backpressure.
    bit rnd_mode = 1'b0;
    bit mr_fixed = 1'b1;
    always @(posedge clk) begin
        #2;
        mem_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : mr_fixed;
    end

    // Scoreboard monitor
    logic [31:0]       exp_d[$];
    logic [ADDR_W-1:0] exp_a[$];
    int                exp_k = 0;
    bit                hold = 1'b0;
    logic [ADDR_W-1:0] hold_a;
    logic [31:0]       hold_d;
    bit                tb_idle = 1'b1;
    int                done_cnt = 0;

    always @(negedge clk) begin
        int occ;
        if (rst) begin
            exp_d.delete();
            exp_a.delete();
            exp_k = 0;
            hold  = 1'b0;
        end else begin
            occ = exp_d.size();
            if (start && tb_idle) exp_k = 0;
            chk("mem_we_vs_model", mem_we, occ != 0);
            if (in_ready) chk("in_ready_not_full", occ < DEPTH, 1);
            if (hold) begin
                chk("hold_addr", mem_addr, hold_a);
                chk("hold_data", mem_wdata, hold_d);
            end
            if (mem_we && mem_ready) begin
                if (occ == 0) chk("write_with_empty_model", mem_we, 0);
                else begin
                    chk("wr_addr", mem_addr, exp_a.pop_front());
                    chk("wr_data", mem_wdata, exp_d.pop_front());
                end
            end
            hold   = mem_we && !mem_ready;
            hold_a = mem_addr;
            hold_d = mem_wdata;
            if (in_valid && in_ready && in_fmt != 2'd3) begin
                exp_d.push_back(model_word(in_fmt, in_opcode, in_rs, in_rt, in_rd,
                                           in_shamt, in_funct, in_imm, in_target));
                exp_a.push_back(ADDR_W'(exp_k % (1 << ADDR_W)));
                exp_k++;
            end
            if (done) done_cnt++;
        end
    end

    logic [1:0] w_addrs[$];
    always @(negedge clk) begin
        if (!rst && w_mem_we && w_mem_ready) w_addrs.push_back(w_mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int op, input int rs, input int rt, input int rd,
                              input int sh, input int fn, input int imm, input int tgt);
        in_opcode = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt);
    endtask

    task automatic rand_fields();
        set_fields($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic send(input logic [1:0] fmt);
        bit ok = 1'b0;
        in_fmt   = fmt;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", in_ready, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start   = 1'b0;
        tb_idle = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({nm, "_done"}, done, 1);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, done, 0);
        chk({nm, "_idle"}, busy, 0);
        tb_idle = 1'b1;
        tick();
    endtask

    task automatic w_send();
        bit ok = 1'b0;
        in_fmt = 2'd2;
        rand_fields();
        w_in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (w_in_ready) ok = 1'b1;
            tick();
        end
        w_in_valid = 1'b0;
        if (!ok) chk("wrap_accept_timeout", w_in_ready, 1);
    endtask

    task automatic wrap_session(input int nwords, input int exp_cnt);
        int  base_i = w_addrs.size();
        bit  seen   = 1'b0;
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        repeat (nwords) w_send();
        w_finish = 1'b1;
        tick();
        w_finish = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (w_done) seen = 1'b1;
        end
        chk("wrap_done", w_done, 1);
        tick();
        chk("wrap_nwrites", w_addrs.size() - base_i, nwords);
        for (int i = 0; i < nwords; i++)
            if (base_i + i < w_addrs.size()) chk("wrap_addr", w_addrs[base_i + i], (3 + i) % 4);
        chk("wrap_count", w_count, exp_cnt);
    endtask

    initial begin
        int legal;
        bit any_bad;
        int d0;
        logic [1:0] f;

        // Reset values
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        chk("rst_wrap_addr", w_mem_addr, 3);

        // Basic R-type and first-write latency
        pulse_start();
        chk("load_busy", busy, 1);
        chk("load_in_ready", in_ready, 1);
        set_fields(0, 1, 2, 3, 0, 32'h20, 0, 0);
        send(2'd0);
        chk("r_we_next_cycle", mem_we, 1);
        chk("r_wdata", mem_wdata, 32'h0022_1820);
        chk("r_addr", mem_addr, 0);
        pulse_finish();
        wait_done("basic");
        chk("basic_count", count, 1);

        // I then J, with finish in the same cycle as the J accept
        pulse_start();
        set_fields(32'h23, 29, 8, 0, 0, 0, 16'h0004, 0);
        send(2'd1);
        set_fields(2, 0, 0, 0, 0, 0, 0, 26'h10);
        in_fmt   = 2'd2;
        in_valid = 1'b1;
        finish   = 1'b1;
        @(negedge clk);
        chk("j_ready_with_finish", in_ready, 1);
        tick();
        in_valid = 1'b0;
        finish   = 1'b0;
        chk("i_or_j_word_pending", mem_we, 1);
        wait_done("ij");
        chk("ij_count", count, 2);

        // start+finish in IDLE starts a session; start inside LOAD is ignored
        start  = 1'b1;
        finish = 1'b1;
        tick();
        start   = 1'b0;
        finish  = 1'b0;
        tb_idle = 1'b0;
        chk("startfin_busy", busy, 1);
        chk("startfin_ready", in_ready, 1);
        rand_fields();
        send(2'd0);
        pulse_start();
        rand_fields();
        send(2'd1);
        pulse_finish();
        wait_done("ignore_start");
        chk("ignore_start_count", count, 2);

        // Backpressure: 4 accepts fill the buffer, then release
        mr_fixed = 1'b0;
        pulse_start();
        repeat (4) begin
            rand_fields();
            send(2'($urandom_range(0, 2)));
        end
        rand_fields();
        in_fmt   = 2'd1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_addr_held", mem_addr, 0);
            tick();
        end
        mr_fixed = 1'b1;
        send(2'd1);
        rand_fields();
        send(2'd0);
        pulse_finish();
        wait_done("bp");
        chk("bp_count", count, 6);

        // Illegal format between two legal bundles
        pulse_start();
        chk("illegal_err_clear", err, 0);
        rand_fields();
        send(2'd0);
        rand_fields();
        send(2'd3);
        chk("illegal_err_set", err, 1);
        rand_fields();
        send(2'd1);
        pulse_finish();
        wait_done("illegal");
        chk("illegal_err_sticky", err, 1);
        chk("illegal_count", count, 2);
        pulse_start();
        chk("start_clears_err", err, 0);
        chk("start_clears_count", count, 0);
        pulse_finish();
        wait_done("empty");
        chk("empty_count", count, 0);

        // Randomized sessions under random memory backpressure
        rnd_mode = 1'b1;
        for (int s = 0; s < 3; s++) begin
            legal   = 0;
            any_bad = 1'b0;
            pulse_start();
            for (int i = 0; i < 24; i++) begin
                f = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                rand_fields();
                send(f);
                if (f == 2'd3) any_bad = 1'b1;
                else legal++;
                repeat ($urandom_range(0, 2)) tick();
            end
            pulse_finish();
            wait_done("rand");
            chk("rand_count", count, legal);
            chk("rand_err", err, any_bad);
        end
        rnd_mode = 1'b0;
        mr_fixed = 1'b1;
        tick();

        // Reset in the middle of a drain
        mr_fixed = 1'b0;
        pulse_start();
        repeat (3) begin
            rand_fields();
            send(2'd0);
        end
        pulse_finish();
        tick();
        chk("drain_busy", busy, 1);
        chk("drain_we", mem_we, 1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        mr_fixed = 1'b1;
        tb_idle  = 1'b1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count, 0);
        chk("midrst_in_ready", in_ready, 0);
        d0 = done_cnt;
        repeat (5) tick();
        chk("midrst_no_done", done_cnt, d0);
        chk("midrst_still_no_we", mem_we, 0);

        // Narrow address: pointer wraps, count saturates at 4
        wrap_session(3, 3);
        wrap_session(6, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
